// File: rtl/mul_share_pkg.sv
// Shared types and the round-robin helper for the multiplier share arbiter.
// Tag ids are sized for the largest supported requester count (8).
package mul_share_pkg;

  localparam int MUL_DATA_W = 32;
  localparam int MAX_REQ    = 8;
  localparam int MUL_ID_W   = $clog2(MAX_REQ);

  typedef struct packed {
    logic                valid;
    logic [MUL_ID_W-1:0] id;
  } mul_tag_t;

  // First eligible index at or after rr_ptr, modulo n; one-hot result.
  function automatic logic [MAX_REQ-1:0] rr_pick(
    input logic [MAX_REQ-1:0]  eligible,
    input logic [MUL_ID_W-1:0] rr_ptr,
    input int                  n
  );
    logic [MAX_REQ-1:0] g;
    int                 idx;
    g = '0;
    for (int o = 0; o < MAX_REQ; o++) begin
      idx = (int'(rr_ptr) + o) % n;
      if (o < n && g == '0 && eligible[idx[MUL_ID_W-1:0]])
        g[idx[MUL_ID_W-1:0]] = 1'b1;
    end
    return g;
  endfunction

endpackage

// File: rtl/mul_share_arb_if.sv
// Requester-side request/response bundle of the multiplier share arbiter.
// Slices of the packed buses belong to requester i at [i*DATA_W +: DATA_W].
interface mul_share_arb_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32
);

  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_src1;
  logic [NUM_REQ*DATA_W-1:0] req_src2;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ-1:0]        rsp_valid;
  logic [NUM_REQ*DATA_W-1:0] rsp_data;
  logic [NUM_REQ-1:0]        rsp_ready;

  modport master (
    output req_valid,
    output req_src1,
    output req_src2,
    output rsp_ready,
    input  req_ready,
    input  rsp_valid,
    input  rsp_data
  );

  modport slave (
    input  req_valid,
    input  req_src1,
    input  req_src2,
    input  rsp_ready,
    output req_ready,
    output rsp_valid,
    output rsp_data
  );

endinterface

// File: rtl/mul_tag_pipe.sv
// Fixed-depth tag shift register tracking which requester owns each
// product inside the external multiply cell; reset drops all tags.
module mul_tag_pipe
  import mul_share_pkg::*;
#(
  parameter int MUL_LATENCY = 1
) (
  input  logic     clk,
  input  logic     reset,
  input  mul_tag_t tag_in,
  output mul_tag_t tag_out
);

  mul_tag_t stage [MUL_LATENCY];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < MUL_LATENCY; i++)
        stage[i] <= '0;
    end else begin
      stage[0] <= tag_in;
      for (int i = 1; i < MUL_LATENCY; i++)
        stage[i] <= stage[i-1];
    end
  end

  assign tag_out = stage[MUL_LATENCY-1];

endmodule

// File: rtl/mul_share_arb.sv
// Round-robin share of one pipelined low-word multiplier among NUM_REQ
// requesters. Optional counters: define MUL_SHARE_ARB_STATS_EN.
module mul_share_arb
  import mul_share_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = MUL_DATA_W,
  parameter int MUL_LATENCY = 1
) (
  input  logic              clk,
  input  logic              reset,
  mul_share_arb_if.slave    bus,
  output logic [DATA_W-1:0] mul_src1,
  output logic [DATA_W-1:0] mul_src2,
  input  logic [DATA_W-1:0] mul_result,
  output logic              busy
`ifdef MUL_SHARE_ARB_STATS_EN
  ,
  output logic [31:0]       stat_issue_cnt,
  output logic [31:0]       stat_conflict_cnt
`endif
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]        outstanding;
  logic [NUM_REQ-1:0]        eligible;
  logic [NUM_REQ-1:0]        grant;
  logic [NUM_REQ-1:0]        pop;
  logic [MAX_REQ-1:0]        pick;
  logic                      unused_pick;
  logic [ID_W-1:0]           rr_ptr;
  logic [ID_W-1:0]           rr_next;
  logic [MUL_ID_W-1:0]       grant_id;
  logic [NUM_REQ-1:0]        rsp_valid_q;
  logic [NUM_REQ*DATA_W-1:0] rsp_data_q;
  mul_tag_t                  tag_in;
  mul_tag_t                  tag_out;

  // Registered outstanding blocks a same-cycle pop-and-reissue.
  assign eligible = bus.req_valid & ~outstanding;
  assign pick = rr_pick(MAX_REQ'(eligible),
                        MUL_ID_W'(rr_ptr), NUM_REQ);
  assign unused_pick = |(pick >> NUM_REQ);
  assign grant = reset ? '0 : pick[NUM_REQ-1:0];
  assign pop   = rsp_valid_q & bus.rsp_ready;
  assign busy  = |outstanding;

  assign bus.req_ready = grant;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_data  = rsp_data_q;

  always_comb begin
    grant_id = '0;
    rr_next  = rr_ptr;
    mul_src1 = '0;
    mul_src2 = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) begin
        grant_id = MUL_ID_W'(i);
        rr_next  = (i == NUM_REQ - 1) ? '0 : ID_W'(i + 1);
        mul_src1 = bus.req_src1[i*DATA_W +: DATA_W];
        mul_src2 = bus.req_src2[i*DATA_W +: DATA_W];
      end
    end
  end

  assign tag_in = '{valid: |grant, id: grant_id};

  mul_tag_pipe #(
    .MUL_LATENCY (MUL_LATENCY)
  ) u_tag_pipe (
    .clk     (clk),
    .reset   (reset),
    .tag_in  (tag_in),
    .tag_out (tag_out)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      outstanding <= '0;
      rr_ptr      <= '0;
      rsp_valid_q <= '0;
      rsp_data_q  <= '0;
    end else begin
      outstanding <= (outstanding | grant) & ~pop;
      rr_ptr      <= rr_next;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (tag_out.valid && tag_out.id == MUL_ID_W'(i)) begin
          rsp_valid_q[i]                  <= 1'b1;
          rsp_data_q[i*DATA_W +: DATA_W] <= mul_result;
        end else if (pop[i]) begin
          rsp_valid_q[i] <= 1'b0;
        end
      end
    end
  end

`ifdef MUL_SHARE_ARB_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_issue_cnt    <= '0;
      stat_conflict_cnt <= '0;
    end else begin
      if (|grant)
        stat_issue_cnt <= stat_issue_cnt + 32'd1;
      if ($countones(eligible) > 1)
        stat_conflict_cnt <= stat_conflict_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mul_share_arb.sv
// Directed bench for mul_share_arb with a registered multiply cell model
// and a product scoreboard filled on grant, drained on response pop.
module tb_mul_share_arb;
  import mul_share_pkg::*;

  localparam int N   = 4;
  localparam int W   = 32;
  localparam int LAT = 1;

  typedef struct {
    int          id;
    logic [W-1:0] val;
  } exp_t;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mul_share_arb_if #(.NUM_REQ(N), .DATA_W(W)) bus ();

  logic [W-1:0] mul_src1;
  logic [W-1:0] mul_src2;
  logic [W-1:0] mul_result;
  logic         busy;
`ifdef MUL_SHARE_ARB_STATS_EN
  logic [31:0]  stat_issue_cnt;
  logic [31:0]  stat_conflict_cnt;
`endif

  mul_share_arb #(
    .NUM_REQ     (N),
    .DATA_W      (W),
    .MUL_LATENCY (LAT)
  ) dut (
    .clk               (clk),
    .reset             (reset),
    .bus               (bus.slave),
    .mul_src1          (mul_src1),
    .mul_src2          (mul_src2),
    .mul_result        (mul_result),
    .busy              (busy)
`ifdef MUL_SHARE_ARB_STATS_EN
    ,
    .stat_issue_cnt    (stat_issue_cnt),
    .stat_conflict_cnt (stat_conflict_cnt)
`endif
  );

  // Cell model: product registered LAT edges after presentation.
  logic [W-1:0] cell_pipe [LAT];
  always @(posedge clk) begin
    cell_pipe[0] <= mul_src1 * mul_src2;
    for (int i = 1; i < LAT; i++)
      cell_pipe[i] <= cell_pipe[i-1];
  end
  assign mul_result = cell_pipe[LAT-1];

  logic [W-1:0] a [N];
  logic [W-1:0] b [N];
  always_comb begin
    for (int i = 0; i < N; i++) begin
      bus.req_src1[i*W +: W] = a[i];
      bus.req_src2[i*W +: W] = b[i];
    end
  end

  int   checks = 0;
  int   errors = 0;
  exp_t sb [$];

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] model_mul(input logic [W-1:0] x,
                                             input logic [W-1:0] y);
    logic [63:0] full;
    full = 64'(x) * 64'(y);
    return full[31:0];
  endfunction

  // Scoreboard monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (reset) begin
      sb.delete();
    end else begin
      for (int i = 0; i < N; i++) begin
        if (bus.req_valid[i] && bus.req_ready[i]) begin
          sb.push_back('{id: i, val: model_mul(a[i], b[i])});
          chk("mul_src1", mul_src1, a[i]);
          chk("mul_src2", mul_src2, b[i]);
        end
        if (bus.rsp_valid[i] && bus.rsp_ready[i]) begin
          int k;
          k = -1;
          foreach (sb[j])
            if (k < 0 && sb[j].id == i) k = j;
          chk("rsp_in_sb", 32'(k >= 0), 32'd1);
          if (k >= 0) begin
            chk("rsp_data", bus.rsp_data[i*W +: W], sb[k].val);
            sb.delete(k);
          end
        end
      end
    end
  end

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_rsp(input int i);
    int n;
    n = 0;
    @(negedge clk);
    while (!bus.rsp_valid[i] && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("wait_rsp", 32'(bus.rsp_valid[i]), 32'd1);
  endtask

  task automatic rr_run(input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      chk("rr_order", 32'(bus.req_ready), 32'(1 << (c % N)));
      next_cycle();
      a[c % N] = $urandom;
      b[c % N] = $urandom;
    end
  endtask

  initial begin
    logic [W-1:0] exp2;
    reset         = 1'b1;
    bus.req_valid = '0;
    bus.rsp_ready = '0;
    for (int i = 0; i < N; i++) begin
      a[i] = '0;
      b[i] = '0;
    end
    next_cycle();
    bus.req_valid = '1;
    @(negedge clk);
    chk("ready_in_reset", 32'(bus.req_ready), 32'd0);
    next_cycle();
    reset         = 1'b0;
    bus.req_valid = '0;
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_mul_src1", mul_src1, 32'd0);
    chk("rst_rsp_data0", bus.rsp_data[31:0], 32'd0);

    // Single operation, 3*5.
    next_cycle();
    a[0] = 32'd3;
    b[0] = 32'd5;
    bus.req_valid = 4'b0001;
    @(negedge clk);
    chk("t1_grant", 32'(bus.req_ready), 32'h1);
    next_cycle();
    bus.req_valid = '0;
    @(negedge clk);
    chk("t1_busy", 32'(busy), 32'd1);
    chk("t1_early", 32'(bus.rsp_valid), 32'd0);
    next_cycle();
    bus.rsp_ready = 4'b0001;
    @(negedge clk);
    chk("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    chk("t1_rsp_data", bus.rsp_data[31:0], 32'd15);
    next_cycle();
    bus.rsp_ready = '1;
    @(negedge clk);
    chk("t1_idle", 32'(busy), 32'd0);
    chk("t1_popped", 32'(bus.rsp_valid), 32'd0);

    // Wrap-around products on requester 1.
    next_cycle();
    a[1] = 32'h0001_0000;
    b[1] = 32'h0001_0000;
    bus.req_valid = 4'b0010;
    @(negedge clk);
    chk("t2_grant", 32'(bus.req_ready), 32'h2);
    next_cycle();
    bus.req_valid = '0;
    wait_rsp(1);
    chk("t2_wrap0", bus.rsp_data[W +: W], 32'h0);
    next_cycle();
    a[1] = 32'hFFFF_FFFF;
    b[1] = 32'd2;
    bus.req_valid = 4'b0010;
    @(negedge clk);
    chk("t2_regrant", 32'(bus.req_ready), 32'h2);
    next_cycle();
    bus.req_valid = '0;
    wait_rsp(1);
    chk("t2_wrap1", bus.rsp_data[W +: W], 32'hFFFF_FFFE);
    next_cycle();

    // Contention from a fresh pointer.
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      a[i] = 32'h1111 * (i + 1) + 32'd7;
      b[i] = 32'h0303 * (i + 2);
    end
    bus.req_valid = '1;
    rr_run(8);
    bus.req_valid = '0;
    repeat (4) next_cycle();
    @(negedge clk);
    chk("t3_drained", 32'(busy), 32'd0);

    // Backpressure on requester 2.
    next_cycle();
    bus.req_valid = 4'b0100;
    @(negedge clk);
    chk("t4_grant2", 32'(bus.req_ready), 32'h4);
    exp2 = model_mul(a[2], b[2]);
    next_cycle();
    a[2] = 32'h7;
    b[2] = 32'h9;
    bus.req_valid = '1;
    bus.rsp_ready = 4'b1011;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk("bp_no_grant2", 32'(bus.req_ready[2]), 32'd0);
      chk("bp_others", 32'(|bus.req_ready), 32'd1);
      if (k >= 1)
        chk("bp_hold", bus.rsp_data[2*W +: W], exp2);
      next_cycle();
    end
    bus.rsp_ready = '1;
    @(negedge clk);
    chk("pop_no_regrant", 32'(bus.req_ready[2]), 32'd0);
    chk("pop_valid", 32'(bus.rsp_valid[2]), 32'd1);
    next_cycle();
    bus.req_valid = '0;
    repeat (5) next_cycle();
    @(negedge clk);
    chk("t4_drained", 32'(busy), 32'd0);

    // Reset on the edge after requester 3 issues.
    next_cycle();
    bus.req_valid = 4'b1000;
    @(negedge clk);
    chk("t5_grant3", 32'(bus.req_ready), 32'h8);
    next_cycle();
    reset = 1'b1;
    bus.req_valid = 4'b0001;
    @(negedge clk);
    chk("t5_ready_rst", 32'(bus.req_ready), 32'd0);
    next_cycle();
    reset = 1'b0;
    bus.req_valid = '0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("t5_no_rsp", 32'(bus.rsp_valid), 32'd0);
      chk("t5_busy", 32'(busy), 32'd0);
      next_cycle();
    end
    bus.req_valid = '1;
    rr_run(8);
    bus.req_valid = '0;
`ifdef MUL_SHARE_ARB_STATS_EN
    // Every one of the 8 grant cycles had at least two eligible requesters.
    @(negedge clk);
    chk("stat_issue", stat_issue_cnt, 32'd8);
    chk("stat_conflict", stat_conflict_cnt, 32'd8);
`endif
    repeat (5) next_cycle();
    @(negedge clk);
    chk("final_busy", 32'(busy), 32'd0);
    next_cycle();
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
